// File: rtl/ssd_scan_driver_if.sv
// Display-side bundle of the seven-segment scan driver: symbol codes and blink
// mask in, active-low digit enables and segments out.
interface ssd_scan_driver_if;
   logic [19:0] ssd;
   logic [3:0]  blink_mask;
   logic [3:0]  AN;
   logic [6:0]  seven_out;

   modport master (output ssd, output blink_mask, input AN, input seven_out);
   modport slave  (input ssd, input blink_mask, output AN, output seven_out);
endinterface

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-level anti-tearing snapshot.
// Optional blinking is compiled in with macro SSD_BLINK_EN.
module ssd_scan_driver #(
   parameter int DIGIT_CYCLES      = 100000,
   parameter int BLINK_HALF_CYCLES = 50000000
) (
   input  logic               clk,
   input  logic               rst,
   ssd_scan_driver_if.slave   bus
);
   localparam int             PW       = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [PW-1:0]  P_LAST   = PW'(DIGIT_CYCLES - 1);
   localparam logic [19:0]    BLANK4   = {4{5'd19}};
   localparam logic [6:0]     SEG_OFF  = 7'b1111111;

   logic [PW-1:0] presc_reg;
   logic [1:0]    idx_reg;
   logic [19:0]   snap_reg;
   logic          started_reg;
   logic [3:0]    an_reg;
   logic [6:0]    seg_reg;

   logic [4:0]    slot_code [4];
   logic          slot_end;
   logic          frame_end;
   logic          blank_now;
   logic [3:0]    an_next;
   logic [6:0]    seg_next;

   function automatic logic [6:0] decode(input logic [4:0] code);
      logic [6:0] seg;
      case (code)
         5'd0:    seg = 7'b0000001;
         5'd1:    seg = 7'b1001111;
         5'd2:    seg = 7'b0010010;
         5'd3:    seg = 7'b0000110;
         5'd4:    seg = 7'b1001100;
         5'd5:    seg = 7'b0100100;
         5'd6:    seg = 7'b0100000;
         5'd7:    seg = 7'b0001111;
         5'd8:    seg = 7'b0000000;
         5'd9:    seg = 7'b0000100;
         5'd10:   seg = 7'b0110001;
         5'd11:   seg = 7'b1110001;
         5'd12:   seg = 7'b0100100;
         5'd13:   seg = 7'b1000010;
         5'd14:   seg = 7'b0000001;
         5'd15:   seg = 7'b0011000;
         5'd16:   seg = 7'b0110000;
         5'd17:   seg = 7'b1101010;
         5'd18:   seg = 7'b1111110;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   // Index i shows the leftmost-first slice of the frozen snapshot.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_slot
         assign slot_code[gi] = snap_reg[19 - 5*gi -: 5];
      end
   endgenerate

   assign slot_end  = (presc_reg == P_LAST);
   assign frame_end = slot_end && (idx_reg == 2'd3);
   assign an_next   = ~(4'b1000 >> idx_reg);

`ifdef SSD_BLINK_EN
   localparam int             BW      = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
   localparam logic [BW-1:0]  B_LAST  = BW'(BLINK_HALF_CYCLES - 1);

   logic [BW-1:0] blink_cnt_reg;
   logic          phase_on_reg;
   logic [3:0]    mask_reg;

   assign blank_now = !phase_on_reg && mask_reg[3 - idx_reg];

   // Mask is latched at slot boundaries so a change never cuts a digit slot short.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_reg <= '0;
         phase_on_reg  <= 1'b1;
         mask_reg      <= 4'b0000;
      end else if (!started_reg) begin
         mask_reg      <= bus.blink_mask;
      end else begin
         if (blink_cnt_reg == B_LAST) begin
            blink_cnt_reg <= '0;
            phase_on_reg  <= !phase_on_reg;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
         end
         if (slot_end) begin
            mask_reg <= bus.blink_mask;
         end
      end
   end
`else
   wire unused_blink_mask = ^bus.blink_mask;
   assign blank_now = 1'b0;
`endif

   assign seg_next = blank_now ? SEG_OFF : decode(slot_code[idx_reg]);

   // The first cycle after reset only loads the snapshot, so digit 0 appears one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_reg   <= '0;
         idx_reg     <= 2'd0;
         snap_reg    <= BLANK4;
         started_reg <= 1'b0;
         an_reg      <= 4'b1111;
         seg_reg     <= SEG_OFF;
      end else if (!started_reg) begin
         started_reg <= 1'b1;
         snap_reg    <= bus.ssd;
      end else begin
         an_reg  <= an_next;
         seg_reg <= seg_next;
         if (slot_end) begin
            presc_reg <= '0;
            idx_reg   <= idx_reg + 2'd1;
         end else begin
            presc_reg <= presc_reg + 1'b1;
         end
         if (frame_end) begin
            snap_reg <= bus.ssd;
         end
      end
   end

   assign bus.AN        = an_reg;
   assign bus.seven_out = seg_reg;
endmodule
